control_fsm_param: RTL and testbench
====================================

Name: control_fsm_param

Overview:
- Parametrised next-generation processor control unit.
- Decodes IR[top:top-3] and sequences Fetch/Decode/Execute for the datapath: PC, instruction memory, data memory, register file and ALU.
- Compared with the current control FSM, it adds:
  - configurable register/address width
  - a programmable data-memory wait count
  - load-immediate, jump and jump-if-zero instructions
  - a resumable Halt
  - a sticky illegal-opcode error flag
- Sits in the ControlUnit between the IR and the datapath muxes/enables.

Parameters:
RA_W, 4, register-file address width; IR width = 4 + 3*RA_W, data address width DA_W = 2*RA_W
ALU_S_W, 3, ALU function-select width
MEM_LAT, 1, data-memory read latency in cycles (>=1); Load_A is held this many cycles
ADD_SEL, 1, ALU select code driven for Add
SUB_SEL, 2, ALU select code driven for Sub

Ports:
Clk  in  1  clock, rising edge
ResetN  in  1  asynchronous, active-low reset
IR  in  4+3*RA_W  instruction register contents
Ra_zero  in  1  high when RF A-side read data == 0
Run  in  1  resume request, sampled only in Halt
PC_clr  out  1  clear PC
PC_up  out  1  increment PC
PC_ld  out  1  load PC from PC_addr
PC_addr  out  DA_W  jump target = IR[DA_W-1:0]
IR_ld  out  1  load IR
D_addr  out  DA_W  data memory address
D_wr  out  1  data memory write enable
RF_s  out  2  RF write mux: 0 = ALU, 1 = memory, 2 = immediate
Imm  out  DA_W  immediate = IR[DA_W-1:0]
RF_W_en  out  1  RF write enable
RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  RA_W each  RF addresses
Alu_s0  out  ALU_S_W  ALU function select
Err  out  1  sticky illegal-opcode flag
CurrentState, NextState  out  State  debug visibility

Behaviour:
- Outputs are Moore (decoded from CurrentState and IR only). Default for every output is 0.
- Reset:
  - ResetN low forces CurrentState = Init and Err = 0 immediately (asynchronous).
  - While in reset, the only non-zero output is PC_clr = 1.
  - Reset mid-instruction abandons that instruction; no partial D_wr or RF_W_en is issued after reset asserts.
- Opcodes:
  - 0 Noop, 1 Store, 2 Load, 3 Add, 4 Sub, 5 Halt, 6 Ldi, 7 Jmp, 8 Jz.
  - 9-15 are illegal.
- Field slices for fields A/B/C:
  - A = IR[3*RA_W-1:2*RA_W]
  - B = IR[2*RA_W-1:RA_W]
  - C = IR[RA_W-1:0]
- States and transitions:
  - Init: PC_clr = 1. Next: Fetch.
  - Fetch: IR_ld = 1, PC_up = 1. Next: Decode.
  - Decode: no outputs. Next state is chosen by opcode. Illegal opcode sets Err = 1 and goes to Halt.
  - Noop: next Fetch.
  - Store: D_addr = IR[DA_W-1:0], D_wr = 1, RF_Ra_addr = A. Next: Fetch.
  - Load_A:
    - Outputs: D_addr = IR[DA_W+RA_W-1:RA_W], RF_s = 1, RF_W_addr = C.
    - Wait counter loads MEM_LAT-1 on entry. Load_A is held until the counter reaches 0, so it lasts exactly MEM_LAT cycles. Next: Load_B.
  - Load_B: same outputs as Load_A plus RF_W_en = 1. Next: Fetch.
  - Add / Sub:
    - RF_Ra_addr = A, RF_Rb_addr = B, RF_W_addr = C, RF_W_en = 1, RF_s = 0.
    - Alu_s0 = ADD_SEL for Add, SUB_SEL for Sub. Next: Fetch.
  - Ldi: RF_s = 2, Imm = IR[DA_W-1:0], RF_W_addr = A, RF_W_en = 1. Next: Fetch.
  - Jmp: PC_ld = 1, PC_addr = IR[DA_W-1:0]. Next: Fetch.
  - Jz: RF_Ra_addr = A, PC_addr = IR[DA_W-1:0], PC_ld = Ra_zero (same cycle). Next: Fetch.
  - Halt: all outputs 0. If Run = 1 next Fetch, else stay. Run has no effect while Err = 1 (only reset clears it).
- Latency from ResetN release:
  - Fetch occurs on the 1st rising edge, Decode on the 2nd, the execute state on the 3rd.
  - Instruction cycle lengths: 3 cycles for every instruction except Load, which takes 3 + MEM_LAT.
- Unreachable state encodings go to Init.
- PC_up and PC_ld are never both 1.

Decomposition:
- Shared package ctrl_pkg:
  - State enum (Init, Fetch, Decode, Noop, Store, Load_A, Load_B, Add, Sub, Ldi, Jmp, Jz, Halt)
  - Opcode enum
  - RF_s select constants (RF_S_ALU = 0, RF_S_MEM = 1, RF_S_IMM = 2)
  - state/opcode-to-string functions
- Sub-module wait_counter:
  - Down-counter of width $clog2(MEM_LAT+1) with load and done signals.
  - Asynchronous active-low reset to 0.

Test Plan:
1. Reset pulse mid-Store (ResetN low during Store) -> CurrentState = Init, D_wr = 0 in the same cycle, PC_clr = 1, Err = 0.
2. IR = 16'h3125 (Add R1+R2 -> R5) after reset -> state Add on the 3rd edge, RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 5, Alu_s0 = 1, RF_W_en = 1.
3. MEM_LAT = 3, IR = 16'h2A47 -> Load_A for exactly 3 cycles with D_addr = 8'hA4, RF_W_addr = 7, RF_W_en = 0; then Load_B one cycle with RF_W_en = 1; then Fetch.
4. IR = 16'h83C0:
   - With Ra_zero = 1 -> Jz state, RF_Ra_addr = 3, PC_ld = 1, PC_addr = 8'hC0.
   - Repeat with Ra_zero = 0 -> PC_ld = 0.
5. IR = 16'h5000 -> Halt, held for 10 cycles with Run = 0; Run = 1 for one cycle -> Fetch on the next edge with IR_ld = 1.
6. IR = 16'hF000 -> Decode sets Err = 1, then Halt. Run = 1 keeps Halt; only ResetN low clears Err.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state/opcode types, RF write-mux codes and debug string helpers
package ctrl_pkg;

  typedef enum logic [3:0] {
    Init, Fetch, Decode, Noop, Store, Load_A, Load_B, Add, Sub, Ldi, Jmp, Jz, Halt
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT, OP_LDI, OP_JMP, OP_JZ
  } opcode_t;

  localparam logic [1:0] RF_S_ALU = 2'd0;
  localparam logic [1:0] RF_S_MEM = 2'd1;
  localparam logic [1:0] RF_S_IMM = 2'd2;

  function automatic string state_str(state_t s);
    case (s)
      Init:    return "Init";
      Fetch:   return "Fetch";
      Decode:  return "Decode";
      Noop:    return "Noop";
      Store:   return "Store";
      Load_A:  return "Load_A";
      Load_B:  return "Load_B";
      Add:     return "Add";
      Sub:     return "Sub";
      Ldi:     return "Ldi";
      Jmp:     return "Jmp";
      Jz:      return "Jz";
      Halt:    return "Halt";
      default: return "Bad";
    endcase
  endfunction

  function automatic string op_str(opcode_t o);
    case (o)
      OP_NOOP:  return "noop";
      OP_STORE: return "store";
      OP_LOAD:  return "load";
      OP_ADD:   return "add";
      OP_SUB:   return "sub";
      OP_HALT:  return "halt";
      OP_LDI:   return "ldi";
      OP_JMP:   return "jmp";
      OP_JZ:    return "jz";
      default:  return "illegal";
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_param_wait_counter.sv
// wait_counter: loadable down-counter that holds at zero; done flags zero
module wait_counter #(
  parameter int W = 1
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/control_fsm_param.sv
// control_fsm_param: Moore fetch/decode/execute sequencer driving PC, memories, RF and ALU
module control_fsm_param
  import ctrl_pkg::*;
#(
  parameter int RA_W    = 4,
  parameter int ALU_S_W = 3,
  parameter int MEM_LAT = 1,
  parameter int ADD_SEL = 1,
  parameter int SUB_SEL = 2,
  localparam int IR_W   = 4 + 3*RA_W,
  localparam int DA_W   = 2*RA_W
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic [IR_W-1:0]    IR,
  input  logic               Ra_zero,
  input  logic               Run,
  output logic               PC_clr,
  output logic               PC_up,
  output logic               PC_ld,
  output logic [DA_W-1:0]    PC_addr,
  output logic               IR_ld,
  output logic [DA_W-1:0]    D_addr,
  output logic               D_wr,
  output logic [1:0]         RF_s,
  output logic [DA_W-1:0]    Imm,
  output logic               RF_W_en,
  output logic [RA_W-1:0]    RF_W_addr,
  output logic [RA_W-1:0]    RF_Ra_addr,
  output logic [RA_W-1:0]    RF_Rb_addr,
  output logic [ALU_S_W-1:0] Alu_s0,
  output logic               Err,
  output state_t             CurrentState,
  output state_t             NextState
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [3:0]      op;
  logic [RA_W-1:0] fa, fb, fc;
  logic [DA_W-1:0] lo, mid;
  logic            illegal, wait_done;

  assign op      = IR[IR_W-1 -: 4];
  assign fa      = IR[3*RA_W-1:2*RA_W];
  assign fb      = IR[2*RA_W-1:RA_W];
  assign fc      = IR[RA_W-1:0];
  assign lo      = IR[DA_W-1:0];
  assign mid     = IR[DA_W+RA_W-1:RA_W];
  assign illegal = op > 4'd8;

  // Armed while leaving Decode so Load_A lasts exactly MEM_LAT cycles
  wait_counter #(.W(CW)) u_wait (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .load     (CurrentState == Decode && op == OP_LOAD),
    .load_val (CW'(MEM_LAT - 1)),
    .done     (wait_done)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      CurrentState <= Init;
      Err          <= 1'b0;
    end else begin
      CurrentState <= NextState;
      if (CurrentState == Decode && illegal) Err <= 1'b1;
    end
  end

  always_comb begin
    NextState = Init;
    case (CurrentState)
      Init:    NextState = Fetch;
      Fetch:   NextState = Decode;
      Decode: begin
        case (op)
          OP_NOOP:  NextState = Noop;
          OP_STORE: NextState = Store;
          OP_LOAD:  NextState = Load_A;
          OP_ADD:   NextState = Add;
          OP_SUB:   NextState = Sub;
          OP_HALT:  NextState = Halt;
          OP_LDI:   NextState = Ldi;
          OP_JMP:   NextState = Jmp;
          OP_JZ:    NextState = Jz;
          default:  NextState = Halt;
        endcase
      end
      Load_A:  NextState = wait_done ? Load_B : Load_A;
      Halt:    NextState = (Run && !Err) ? Fetch : Halt;
      Noop, Store, Load_B, Add, Sub, Ldi, Jmp, Jz: NextState = Fetch;
      default: NextState = Init;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_addr    = '0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = RF_S_ALU;
    Imm        = '0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    Alu_s0     = '0;
    case (CurrentState)
      Init: PC_clr = 1'b1;
      Fetch: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      Store: begin
        D_addr     = lo;
        D_wr       = 1'b1;
        RF_Ra_addr = fa;
      end
      Load_A, Load_B: begin
        D_addr    = mid;
        RF_s      = RF_S_MEM;
        RF_W_addr = fc;
        RF_W_en   = CurrentState == Load_B;
      end
      Add, Sub: begin
        RF_Ra_addr = fa;
        RF_Rb_addr = fb;
        RF_W_addr  = fc;
        RF_W_en    = 1'b1;
        Alu_s0     = CurrentState == Add ? ALU_S_W'(ADD_SEL) : ALU_S_W'(SUB_SEL);
      end
      Ldi: begin
        RF_s      = RF_S_IMM;
        Imm       = lo;
        RF_W_addr = fa;
        RF_W_en   = 1'b1;
      end
      Jmp: begin
        PC_ld   = 1'b1;
        PC_addr = lo;
      end
      Jz: begin
        RF_Ra_addr = fa;
        PC_addr    = lo;
        PC_ld      = Ra_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm_param.sv
// tb_control_fsm_param: scoreboard bench; per-cycle expected output bundles queued at drive time
module tb_control_fsm_param;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr, pc_up, pc_ld;
    logic [7:0] pc_addr;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic [1:0] rf_s;
    logic [7:0] imm;
    logic       w_en;
    logic [3:0] w_addr, ra, rb;
    logic [2:0] alu;
    logic       err;
  } ent_t;

  logic        Clk = 1'b0;
  logic        ResetN, Ra_zero, Run;
  logic [15:0] IR;
  logic        PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_W_en, Err;
  logic [7:0]  PC_addr, D_addr, Imm;
  logic [1:0]  RF_s;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  Alu_s0;
  state_t      CurrentState, NextState;

  ent_t q[$];
  ent_t x, a, e;
  logic exp_err;
  int   n_chk = 0, n_pass = 0;

  control_fsm_param #(.MEM_LAT(3)) dut (
    .Clk(Clk), .ResetN(ResetN), .IR(IR), .Ra_zero(Ra_zero), .Run(Run),
    .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_addr(PC_addr), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .Imm(Imm), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .Alu_s0(Alu_s0), .Err(Err), .CurrentState(CurrentState), .NextState(NextState)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic ent_t blank(state_t s);
    ent_t b = '0;
    b.st  = s;
    b.err = exp_err;
    return b;
  endfunction

  task automatic fd(input logic [15:0] ir, input logic rz);
    ent_t f;
    IR      = ir;
    Ra_zero = rz;
    f = blank(Fetch);
    f.ir_ld = 1'b1;
    f.pc_up = 1'b1;
    q.push_back(f);
    q.push_back(blank(Decode));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      a = '{st: CurrentState, pc_clr: PC_clr, pc_up: PC_up, pc_ld: PC_ld, pc_addr: PC_addr,
            ir_ld: IR_ld, d_addr: D_addr, d_wr: D_wr, rf_s: RF_s, imm: Imm, w_en: RF_W_en,
            w_addr: RF_W_addr, ra: RF_Ra_addr, rb: RF_Rb_addr, alu: Alu_s0, err: Err};
      check(state_str(state_t'(e.st)), 64'(a), 64'(e));
    end
  end

  initial begin
    ResetN = 1'b0; IR = '0; Ra_zero = 1'b0; Run = 1'b0; exp_err = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_state", 64'(CurrentState), 64'(Init));
    check("rst_pc_clr", 64'(PC_clr), 64'd1);
    check("rst_d_wr", 64'(D_wr), 64'd0);
    check("rst_err", 64'(Err), 64'd0);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    fd(16'h13A5, 1'b0);
    x = blank(Store); x.d_addr = 8'hA5; x.d_wr = 1'b1; x.ra = 4'd3; q.push_back(x);
    drain();
    fd(16'h3125, 1'b0);
    x = blank(Add); x.ra = 4'd1; x.rb = 4'd2; x.w_addr = 4'd5; x.w_en = 1'b1; x.alu = 3'd1;
    q.push_back(x);
    drain();
    fd(16'h4ABC, 1'b0);
    x = blank(Sub); x.ra = 4'hA; x.rb = 4'hB; x.w_addr = 4'hC; x.w_en = 1'b1; x.alu = 3'd2;
    q.push_back(x);
    drain();
    fd(16'h2A47, 1'b0);
    x = blank(Load_A); x.d_addr = 8'hA4; x.rf_s = 2'd1; x.w_addr = 4'd7;
    repeat (3) q.push_back(x);
    x.st = 4'(Load_B); x.w_en = 1'b1; q.push_back(x);
    drain();
    fd(16'h637F, 1'b0);
    x = blank(Ldi); x.rf_s = 2'd2; x.imm = 8'h7F; x.w_addr = 4'd3; x.w_en = 1'b1; q.push_back(x);
    drain();
    fd(16'h7055, 1'b0);
    x = blank(Jmp); x.pc_ld = 1'b1; x.pc_addr = 8'h55; q.push_back(x);
    drain();
    fd(16'h83C0, 1'b1);
    x = blank(Jz); x.ra = 4'd3; x.pc_addr = 8'hC0; x.pc_ld = 1'b1; q.push_back(x);
    drain();
    fd(16'h83C0, 1'b0);
    x.pc_ld = 1'b0; q.push_back(x);
    drain();
    fd(16'h0000, 1'b0);
    q.push_back(blank(Noop));
    drain();
    fd(16'h5000, 1'b0);
    repeat (10) q.push_back(blank(Halt));
    drain();
    Run = 1'b1;
    q.push_back(blank(Halt));
    drain();
    Run = 1'b0;
    check("resume_state", 64'(CurrentState), 64'(Fetch));
    check("resume_ir_ld", 64'(IR_ld), 64'd1);
    fd(16'h13A5, 1'b0);
    drain();
    check("store_d_wr", 64'(D_wr), 64'd1);
    ResetN = 1'b0;
    #1;
    check("midrst_state", 64'(CurrentState), 64'(Init));
    check("midrst_d_wr", 64'(D_wr), 64'd0);
    check("midrst_pc_clr", 64'(PC_clr), 64'd1);
    check("midrst_err", 64'(Err), 64'd0);
    x = blank(Init); x.pc_clr = 1'b1; q.push_back(x);
    drain();
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    fd(16'hF000, 1'b0);
    exp_err = 1'b1;
    repeat (2) q.push_back(blank(Halt));
    drain();
    Run = 1'b1;
    repeat (3) q.push_back(blank(Halt));
    drain();
    Run = 1'b0;
    check("err_sticky", 64'(Err), 64'd1);
    ResetN = 1'b0;
    #1;
    check("err_cleared", 64'(Err), 64'd0);
    check("err_rst_state", 64'(CurrentState), 64'(Init));
    exp_err = 1'b0;
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    fd(16'h0000, 1'b0);
    q.push_back(blank(Noop));
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
